any1_bf_collect: RTL and testbench

Operand-collection and issue stage sitting directly upstream of the ANY-1 bit-field unit. It accepts bit-field instructions whose four source operands (a, b, c, d) may still be outstanding, snoops the result bus until every operand is present, and then issues the instruction in program order. Issued instructions carry fully resolved 64-bit operands and a mask-range overflow flag. Buffering is a 2-entry in-order queue.

---
 rtl/any1_bf_collect.sv | 168 ++++++++++++++++
 tb/tb_any1_bf_collect.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/any1_bf_collect.sv
// ---------------------------------------------------------------------------
// any1_bf_collect
//
// Operand-collection and in-order issue stage in front of the ANY-1 bit-field
// unit. Instructions arrive with up to four operands (a, b, c, d) that may
// still be in flight. Each waiting operand watches the result bus for its
// producer tag. Once all four operands of the oldest instruction are present,
// that instruction is presented to the bit-field unit. Storage is a 2-entry
// circular queue.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flush_i            synchronous flush, discards every queued entry
//   in_valid_i         instruction offered
//   in_ready_o         a free entry exists (low while in reset)
//   in_func_i          bit-field op code
//   in_opv_i           per-operand valid (bit k = operand k)
//   in_optag_i         per-operand producer tag, slice k = operand k
//   in_opval_i         per-operand value, slice k = operand k
//   rb_valid_i         result bus carries a value
//   rb_tag_i           result bus tag
//   rb_val_i           result bus value
//   out_valid_o        head entry complete and presented
//   out_ready_i        bit-field unit accepts the head entry
//   out_func_o         head op code
//   out_a_o..out_d_o   head operands
//   out_ovf_o          head mask range overflows (c[5:0] + d[5:0] > 63)
// ---------------------------------------------------------------------------
module any1_bf_collect #(
    parameter int DWIDTH = 64,
    parameter int TAGW   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            in_func_i,
    input  logic [3:0]            in_opv_i,
    input  logic [4*TAGW-1:0]     in_optag_i,
    input  logic [4*DWIDTH-1:0]   in_opval_i,
    input  logic                  rb_valid_i,
    input  logic [TAGW-1:0]       rb_tag_i,
    input  logic [DWIDTH-1:0]     rb_val_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2:0]            out_func_o,
    output logic [DWIDTH-1:0]     out_a_o,
    output logic [DWIDTH-1:0]     out_b_o,
    output logic [DWIDTH-1:0]     out_c_o,
    output logic [DWIDTH-1:0]     out_d_o,
    output logic                  out_ovf_o
);

    // Entry storage
    logic [2:0]        r_func [2];
    logic [3:0]        r_vld  [2];
    logic [TAGW-1:0]   r_tag  [2][4];
    logic [DWIDTH-1:0] r_val  [2][4];

    // Queue bookkeeping
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;

    logic [1:0]        w_occ;
    logic              w_headDone;
    logic              w_outValid;
    logic              w_alloc;
    logic              w_issue;
    logic [6:0]        w_ovfSum;

    // Which entries currently hold a live instruction. Only these snoop the
    // result bus; a stale entry must not pick up values.
    always_comb begin
        w_occ = 2'b00;
        if (r_count == 2'd2) begin
            w_occ = 2'b11;
        end else if (r_count == 2'd1) begin
            w_occ[r_head] = 1'b1;
        end
    end

    assign w_headDone  = &r_vld[r_head];
    assign w_outValid  = (r_count != 2'd0) & w_headDone;
    assign w_issue     = w_outValid & out_ready_i;
    // Ready is not bypassed by a same-cycle issue: a full queue never accepts.
    assign w_alloc     = in_valid_i & (r_count < 2'd2);
    assign in_ready_o  = (r_count < 2'd2) & ~rst_i;

    // Queue update. Flush wins over both allocation and issue. The tail entry
    // is always unoccupied when allocating, so allocation writes never collide
    // with snoop writes into live entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int e = 0; e < 2; e++) begin
                r_func[e] <= 3'd0;
                r_vld[e]  <= 4'd0;
                for (int k = 0; k < 4; k++) begin
                    r_tag[e][k] <= '0;
                    r_val[e][k] <= '0;
                end
            end
        end else if (flush_i) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int e = 0; e < 2; e++) begin
                r_vld[e] <= 4'd0;
            end
        end else begin
            // Result-bus snoop on every live entry
            for (int e = 0; e < 2; e++) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_occ[e] && !r_vld[e][k] && rb_valid_i &&
                        (r_tag[e][k] == rb_tag_i)) begin
                        r_vld[e][k] <= 1'b1;
                        r_val[e][k] <= rb_val_i;
                    end
                end
            end

            // Allocation, including a snoop of the bus in the same cycle so a
            // result broadcast exactly now is not missed
            if (w_alloc) begin
                r_func[r_tail] <= in_func_i;
                for (int k = 0; k < 4; k++) begin
                    r_tag[r_tail][k] <= in_optag_i[k*TAGW +: TAGW];
                    if (in_opv_i[k]) begin
                        r_vld[r_tail][k] <= 1'b1;
                        r_val[r_tail][k] <= in_opval_i[k*DWIDTH +: DWIDTH];
                    end else if (rb_valid_i &&
                                 (in_optag_i[k*TAGW +: TAGW] == rb_tag_i)) begin
                        r_vld[r_tail][k] <= 1'b1;
                        r_val[r_tail][k] <= rb_val_i;
                    end else begin
                        r_vld[r_tail][k] <= 1'b0;
                        r_val[r_tail][k] <= in_opval_i[k*DWIDTH +: DWIDTH];
                    end
                end
            end

            r_tail <= r_tail ^ w_alloc;
            r_head <= r_head ^ w_issue;

            case ({w_alloc, w_issue})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Mask-range overflow: 7-bit sum so a carry out of bit 5 is visible
    assign w_ovfSum = {1'b0, r_val[r_head][2][5:0]} + {1'b0, r_val[r_head][3][5:0]};

    assign out_valid_o = w_outValid;
    assign out_func_o  = r_func[r_head];
    assign out_a_o     = r_val[r_head][0];
    assign out_b_o     = r_val[r_head][1];
    assign out_c_o     = r_val[r_head][2];
    assign out_d_o     = r_val[r_head][3];
    assign out_ovf_o   = w_ovfSum[6];

endmodule

// File: tb/tb_any1_bf_collect.sv
// ---------------------------------------------------------------------------
// tb_any1_bf_collect
//
// Directed testbench for any1_bf_collect. A queue-based reference model
// tracks what the stage should hold, a compare process checks the outputs
// against it every cycle, and the directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_any1_bf_collect;

    localparam int DW = 64;
    localparam int TW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [2:0]        inFunc;
    logic [3:0]        inOpv;
    logic [4*TW-1:0]   inOptag;
    logic [4*DW-1:0]   inOpval;
    logic              rbValid;
    logic [TW-1:0]     rbTag;
    logic [DW-1:0]     rbVal;
    logic              outValid;
    logic              outReady;
    logic [2:0]        outFunc;
    logic [DW-1:0]     outA;
    logic [DW-1:0]     outB;
    logic [DW-1:0]     outC;
    logic [DW-1:0]     outD;
    logic              outOvf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]           func;
        logic [3:0]           v;
        logic [3:0][TW-1:0]   tag;
        logic [3:0][DW-1:0]   val;
    } ent_t;

    ent_t mq[$];

    any1_bf_collect #(.DWIDTH(DW), .TAGW(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_func_i   (inFunc),
        .in_opv_i    (inOpv),
        .in_optag_i  (inOptag),
        .in_opval_i  (inOpval),
        .rb_valid_i  (rbValid),
        .rb_tag_i    (rbTag),
        .rb_val_i    (rbVal),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_func_o  (outFunc),
        .out_a_o     (outA),
        .out_b_o     (outB),
        .out_c_o     (outC),
        .out_d_o     (outD),
        .out_ovf_o   (outOvf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of pending instructions. Each clock
    // the bus wakes waiting operands, the oldest complete one leaves if the
    // consumer is ready, and a new one joins if there was room.
    always @(posedge clk or posedge rst) begin : modelUpd
        ent_t ne;
        ent_t cur;
        bit   doIssue;
        bit   doAlloc;
        if (rst || flush) begin
            mq.delete();
        end else begin
            doIssue = (mq.size() > 0) && (mq[0].v == 4'hF) && outReady;
            doAlloc = inValid && (mq.size() < 2);
            for (int e = 0; e < mq.size(); e++) begin
                cur = mq[e];
                for (int k = 0; k < 4; k++) begin
                    if (!cur.v[k] && rbValid && cur.tag[k] == rbTag) begin
                        cur.v[k]   = 1'b1;
                        cur.val[k] = rbVal;
                    end
                end
                mq[e] = cur;
            end
            ne.func = inFunc;
            ne.tag  = inOptag;
            ne.val  = inOpval;
            ne.v    = inOpv;
            for (int k = 0; k < 4; k++) begin
                if (!inOpv[k] && rbValid && ne.tag[k] == rbTag) begin
                    ne.v[k]   = 1'b1;
                    ne.val[k] = rbVal;
                end
            end
            if (doIssue) void'(mq.pop_front());
            if (doAlloc) mq.push_back(ne);
        end
    end

    // Every-cycle comparison of the DUT outputs against the model
    always @(negedge clk) begin : compare
        ent_t h;
        bit   expValid;
        expValid = (mq.size() > 0) && (mq[0].v == 4'hF);
        checkOutput("in_ready", 64'(inReady), 64'((mq.size() < 2) && !rst));
        checkOutput("out_valid", 64'(outValid), 64'(expValid));
        if (expValid) begin
            h = mq[0];
            checkOutput("out_func", 64'(outFunc), 64'(h.func));
            checkOutput("out_a", outA, h.val[0]);
            checkOutput("out_b", outB, h.val[1]);
            checkOutput("out_c", outC, h.val[2]);
            checkOutput("out_d", outD, h.val[3]);
            checkOutput("out_ovf", 64'(outOvf),
                        64'((int'(h.val[2][5:0]) + int'(h.val[3][5:0])) > 63));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] f,
                                 input logic [3:0] opv,
                                 input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                                 input logic [TW-1:0] tc, input logic [TW-1:0] td,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] c, input logic [DW-1:0] d);
        inValid = v;
        inFunc  = f;
        inOpv   = opv;
        inOptag = {td, tc, tb, ta};
        inOpval = {d, c, b, a};
    endtask

    task automatic setBus(input logic v, input logic [TW-1:0] tag,
                          input logic [DW-1:0] val);
        rbValid = v;
        rbTag   = tag;
        rbVal   = val;
    endtask

    task automatic idleIn();
        applyStimulus(1'b0, 3'd0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        outReady = 1'b1;
        idleIn();
        setBus(1'b0, 6'd0, 64'd0);

        // Reset state
        repeat (3) tick();
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(inReady), 64'd1);

        // Ready path: all operands present, issues the next cycle
        applyStimulus(1'b1, 3'd5, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'h0123_4567_89AB_CDEF, 64'd0, 64'd8, 64'd7);
        tick();
        idleIn();
        checkOutput("ready_valid", 64'(outValid), 64'd1);
        checkOutput("ready_func", 64'(outFunc), 64'd5);
        checkOutput("ready_a", outA, 64'h0123_4567_89AB_CDEF);
        checkOutput("ready_c", outC, 64'd8);
        checkOutput("ready_ovf", 64'(outOvf), 64'd0);
        tick();
        checkOutput("ready_drained", 64'(outValid), 64'd0);

        // Snoop wakeup on operand b; a non-matching tag must not wake it
        applyStimulus(1'b1, 3'd3, 4'b1101, 6'd0, 6'h12, 6'd0, 6'd0,
                      64'd1, 64'd0, 64'd2, 64'd3);
        tick();
        idleIn();
        checkOutput("wake_wait", 64'(outValid), 64'd0);
        setBus(1'b1, 6'h13, 64'hAA);
        tick();
        checkOutput("wake_wrongtag", 64'(outValid), 64'd0);
        setBus(1'b1, 6'h12, 64'hFF);
        tick();
        setBus(1'b0, 6'd0, 64'd0);
        checkOutput("wake_valid", 64'(outValid), 64'd1);
        checkOutput("wake_b", outB, 64'hFF);
        checkOutput("wake_func", 64'(outFunc), 64'd3);
        tick();
        checkOutput("wake_drained", 64'(outValid), 64'd0);

        // Same-cycle snoop during allocation
        applyStimulus(1'b1, 3'd0, 4'b0111, 6'd0, 6'd0, 6'd0, 6'd5,
                      64'h11, 64'h22, 64'h33, 64'd0);
        setBus(1'b1, 6'd5, 64'd3);
        tick();
        idleIn();
        setBus(1'b0, 6'd0, 64'd0);
        checkOutput("same_valid", 64'(outValid), 64'd1);
        checkOutput("same_d", outD, 64'd3);
        tick();

        // Order and backpressure: incomplete head blocks complete second entry
        applyStimulus(1'b1, 3'd1, 4'b1110, 6'h21, 6'd0, 6'd0, 6'd0,
                      64'd0, 64'h10, 64'h20, 64'h30);
        tick();
        applyStimulus(1'b1, 3'd2, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'hA1, 64'hA2, 64'hA3, 64'hA4);
        tick();
        idleIn();
        checkOutput("order_full", 64'(inReady), 64'd0);
        checkOutput("order_blocked", 64'(outValid), 64'd0);
        tick();
        checkOutput("order_still_blocked", 64'(outValid), 64'd0);
        setBus(1'b1, 6'h21, 64'h5A);
        tick();
        setBus(1'b0, 6'd0, 64'd0);
        checkOutput("order_head_valid", 64'(outValid), 64'd1);
        checkOutput("order_head_func", 64'(outFunc), 64'd1);
        checkOutput("order_head_a", outA, 64'h5A);
        // Offered while full and issuing: must be refused
        applyStimulus(1'b1, 3'd6, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'hDEAD, 64'd0, 64'd0, 64'd0);
        #1;
        checkOutput("order_no_bypass", 64'(inReady), 64'd0);
        tick();
        idleIn();
        checkOutput("order_second_func", 64'(outFunc), 64'd2);
        checkOutput("order_second_a", outA, 64'hA1);
        tick();
        checkOutput("order_drained", 64'(outValid), 64'd0);

        // Overflow flag and stability under backpressure
        outReady = 1'b0;
        applyStimulus(1'b1, 3'd4, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd1, 64'd2, 64'd40, 64'd30);
        tick();
        idleIn();
        checkOutput("ovf_set", 64'(outOvf), 64'd1);
        tick();
        checkOutput("ovf_hold_valid", 64'(outValid), 64'd1);
        checkOutput("ovf_hold_c", outC, 64'd40);
        outReady = 1'b1;
        tick();

        // Back-to-back: boundary sums 63, 64 and masked high bits of c
        applyStimulus(1'b1, 3'd4, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd0, 64'd0, 64'd33, 64'd30);
        tick();
        checkOutput("ovf63_valid", 64'(outValid), 64'd1);
        checkOutput("ovf63", 64'(outOvf), 64'd0);
        applyStimulus(1'b1, 3'd4, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd0, 64'd0, 64'd34, 64'd30);
        tick();
        checkOutput("ovf64", 64'(outOvf), 64'd1);
        checkOutput("b2b_ready", 64'(inReady), 64'd1);
        applyStimulus(1'b1, 3'd4, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd0, 64'd0, 64'h7F, 64'd1);
        tick();
        idleIn();
        checkOutput("ovf_masked", 64'(outOvf), 64'd1);
        tick();
        checkOutput("b2b_drained", 64'(outValid), 64'd0);

        // Flush with two entries queued and a simultaneous offer
        outReady = 1'b0;
        applyStimulus(1'b1, 3'd1, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd7, 64'd7, 64'd7, 64'd7);
        tick();
        applyStimulus(1'b1, 3'd2, 4'b0111, 6'd0, 6'd0, 6'd0, 6'h2A,
                      64'd8, 64'd8, 64'd8, 64'd0);
        tick();
        applyStimulus(1'b1, 3'd3, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd9, 64'd9, 64'd9, 64'd9);
        flush    = 1'b1;
        outReady = 1'b1;
        #1;
        checkOutput("flush_pre_full", 64'(inReady), 64'd0);
        tick();
        flush = 1'b0;
        idleIn();
        checkOutput("flush_valid", 64'(outValid), 64'd0);
        checkOutput("flush_ready", 64'(inReady), 64'd1);
        setBus(1'b1, 6'h2A, 64'h77);
        tick();
        setBus(1'b0, 6'd0, 64'd0);
        checkOutput("flush_no_ghost", 64'(outValid), 64'd0);
        applyStimulus(1'b1, 3'd6, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'h40, 64'd0, 64'd0, 64'd0);
        tick();
        idleIn();
        checkOutput("flush_realloc_func", 64'(outFunc), 64'd6);
        checkOutput("flush_realloc_a", outA, 64'h40);
        tick();

        // Asynchronous reset in the middle of a cycle
        outReady = 1'b0;
        applyStimulus(1'b1, 3'd5, 4'hF, 6'd0, 6'd0, 6'd0, 6'd0,
                      64'd1, 64'd1, 64'd1, 64'd1);
        tick();
        applyStimulus(1'b1, 3'd5, 4'b1110, 6'd9, 6'd0, 6'd0, 6'd0,
                      64'd0, 64'd2, 64'd2, 64'd2);
        tick();
        idleIn();
        checkOutput("arst_pre_valid", 64'(outValid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(outValid), 64'd0);
        checkOutput("arst_ready", 64'(inReady), 64'd0);
        tick();
        rst      = 1'b0;
        outReady = 1'b1;
        setBus(1'b1, 6'd9, 64'h99);
        tick();
        setBus(1'b0, 6'd0, 64'd0);
        checkOutput("arst_no_ghost", 64'(outValid), 64'd0);
        checkOutput("arst_ready_after", 64'(inReady), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
